fpu_sp_addsub: RTL
==================

# fpu_sp_addsub

Pipelined IEEE-754 binary32 adder/subtractor that replaces the single-function, unpipelined subtract unit in the FPU datapath. It takes `din1`, `din2` and a per-operation `op` select (add or subtract). It accepts one operation per clock, returns each result a fixed 4 cycles later, and carries a user tag alongside. It also reports IEEE exception flags, which the earlier unit did not.

## Interface
- `TAG_W`, default 4: width of the sideband tag carried unchanged from input to output (≥1).
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `din1`  in  32  operand A, binary32.
- `din2`  in  32  operand B, binary32.
- `op`  in  1  operation select: 0 = A+B, 1 = A−B.
- `dval`  in  1  operands, `op` and `tag_in` valid this cycle.
- `tag_in`  in  TAG_W  sideband tag.
- `result`  out  32  binary32 result.
- `rdy`  out  1  `result`, `flags` and `tag_out` valid; single-cycle pulse per operation.
- `tag_out`  out  TAG_W  tag of the operation flagged by `rdy`.
- `flags`  out  4  {invalid, overflow, underflow, inexact}.

## Operation
- There is no backpressure: the unit must be able to absorb one operation on every `dval` cycle.
- Effective operation:
  - B's sign is XORed with `op`.
  - Effective subtract occurs when the resulting signs differ.
- Stage S1 (unpack):
  - Classify each operand as zero, normal, inf, qNaN or sNaN.
  - Denormal inputs are treated as signed zero (flush-to-zero).
  - Swap operands so that |A| ≥ |B|, comparing exponent then mantissa.
  - Compute d = eA − eB.
- Stage S2 (align):
  - Form 24-bit significands with the hidden bit.
  - Append guard, round and sticky bits to get 27 bits.
  - Right-shift B by min(d, 27). Bits shifted out are ORed into sticky.
- Stage S3 (add):
  - Compute the 28-bit sum or difference.
  - Compute the leading-zero count of the result.
- Stage S4 (normalize, round, pack):
  - Normalize: 1-bit right shift on carry-out, or left shift by the LZC.
  - Round to nearest, ties to even, using guard/round/sticky.
  - Renormalize if rounding carries out.
  - Pack the result and apply the special cases.
- Special cases, in priority order:
  - Any NaN input → `0x7FC00000`. invalid=1 if either input is an sNaN.
  - inf − inf (effective subtract) → `0x7FC00000`, invalid=1.
  - Exactly one operand inf, or both inf with the same effective sign → that inf.
  - Exact zero result → `+0`, except when both operands are zero and both (post-`op`) signs are negative, which gives `−0`.
  - Biased exponent ≥ 255 after rounding → signed inf, overflow=1, inexact=1.
  - Normalized result below the minimum normal → signed zero, underflow=1, inexact=1.
  - Otherwise, inexact=1 when any of guard/round/sticky is nonzero.
- Flags are per-operation and are not sticky across operations.
- `tag_out` equals the `tag_in` captured with the same operation.

## Timing
- Latency:
  - Operands sampled at rising edge k with `dval`=1.
  - `rdy`=1 with valid `result`/`flags`/`tag_out` during the cycle after edge k+4.
- Throughput: 1 operation per cycle. Back-to-back `dval` gives back-to-back `rdy`, in order.
- A valid bit travels with each stage. Bubbles (`dval`=0) propagate as `rdy`=0.
- When `rdy`=0, `result`, `flags` and `tag_out` hold their last values.
- Reset, asynchronous on `rst_n` falling:
  - All stage valid bits clear.
  - `rdy`=0, `result`=`0x00000000`, `flags`=0, `tag_out`=0.
- Reset during operation:
  - In-flight operations are discarded and produce no `rdy`.
  - The first `dval` sampled after `rst_n` rises gives `rdy` 4 edges later.
- `op` is sampled together with the operands. Changing `op` every cycle is legal.

## Test plan
- Subtract 4.0 − 3.0 (`0x40800000`, `0x40400000`, op=1) → `0x3F800000`. Then 5.5 − 3.0 → `0x40200000`. Both with flags=0 and rdy exactly 4 cycles after dval.
- Back-to-back stream with incrementing tags:
  - Inputs: 1.0+2.0, 2.5−0.5, −1.5+1.5, and a bubble cycle.
  - Expected: `0x40400000`, `0x40000000`, `0x00000000` on consecutive rdy cycles, tags in order, then rdy=0.
- Specials:
  - inf−inf (`0x7F800000`, `0x7F800000`, op=1) → `0x7FC00000`, invalid=1.
  - `0x7FA00000`+1.0 → `0x7FC00000`, invalid=1.
  - `0x80000000`+`0x80000000` → `0x80000000`.
- Rounding and overflow:
  - `0x3F800000`+`0x33800000` (tie) → `0x3F800000`, inexact=1.
  - `0x3F800001`+`0x33800000` → `0x3F800002`, inexact=1.
  - `0x7F7FFFFF`+`0x7F7FFFFF` → `0x7F800000`, overflow=1, inexact=1.
- Underflow / FTZ:
  - `0x00800001`−`0x00800000` → `0x00000000`, underflow=1.
  - Denormal `0x00000001`+1.0 → `0x3F800000`, flags=0.
- Reset mid-stream: issue 3 ops, assert rst_n low 1 cycle after the second → no rdy for any of them, all outputs 0. The next op after release completes with correct latency.

Source files
------------

// File: rtl/fpu_sp_addsub.sv
// Pipelined binary32 adder/subtractor: input rank plus four stages (unpack, align, add, normalize/round/pack).
// Denormal inputs flush to zero; each result returns with IEEE flags and the caller's tag.
module fpu_sp_addsub #(
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      din1,
    input  logic [31:0]      din2,
    input  logic             op,
    input  logic             dval,
    input  logic [TAG_W-1:0] tag_in,
    output logic [31:0]      result,
    output logic             rdy,
    output logic [TAG_W-1:0] tag_out,
    output logic [3:0]       flags
);
    localparam int          STAGES = 4;
    localparam logic [31:0] QNAN   = 32'h7FC0_0000;

    typedef struct packed {
        logic        spec;
        logic [31:0] spec_res;
        logic [3:0]  spec_flg;
        logic        zsign;
        logic        sign;
        logic [7:0]  exp;
    } side_t;

    logic [STAGES:0]              vld_pipe_q;
    logic [STAGES-1:0][TAG_W-1:0] tag_pipe_q;

    logic [31:0] a0_q, b0_q;
    logic        op0_q;

    // S1 unpack / classify / swap
    logic        sa, sb, za, zb, ia, ib, na, nb, swap;
    logic [7:0]  ea, eb;
    logic [22:0] ma, mb;
    logic [30:0] key_a, key_b;
    logic [23:0] sig_a, sig_b;
    side_t       s1_d, s1_q;
    logic [23:0] sig_l1_d, sig_s1_d, sig_l1_q, sig_s1_q;
    logic [7:0]  d1_d, d1_q;
    logic        sub1_d, sub1_q;

    always_comb begin
        sa    = a0_q[31];
        sb    = b0_q[31] ^ op0_q;
        ea    = a0_q[30:23];
        eb    = b0_q[30:23];
        ma    = a0_q[22:0];
        mb    = b0_q[22:0];
        za    = (ea == 8'h00);
        zb    = (eb == 8'h00);
        ia    = (ea == 8'hFF) && (ma == 23'd0);
        ib    = (eb == 8'hFF) && (mb == 23'd0);
        na    = (ea == 8'hFF) && (ma != 23'd0);
        nb    = (eb == 8'hFF) && (mb != 23'd0);
        key_a = {ea, za ? 23'd0 : ma};
        key_b = {eb, zb ? 23'd0 : mb};
        sig_a = za ? 24'd0 : {1'b1, ma};
        sig_b = zb ? 24'd0 : {1'b1, mb};
        swap  = key_b > key_a;

        sub1_d   = sa ^ sb;
        sig_l1_d = swap ? sig_b : sig_a;
        sig_s1_d = swap ? sig_a : sig_b;
        d1_d     = swap ? (eb - ea) : (ea - eb);

        s1_d       = '0;
        s1_d.zsign = sa & sb;
        s1_d.sign  = swap ? sb : sa;
        s1_d.exp   = swap ? eb : ea;
        if (na || nb) begin
            s1_d.spec     = 1'b1;
            s1_d.spec_res = QNAN;
            s1_d.spec_flg = {(na & ~ma[22]) | (nb & ~mb[22]), 3'b000};
        end else if (ia && ib && (sa != sb)) begin
            s1_d.spec     = 1'b1;
            s1_d.spec_res = QNAN;
            s1_d.spec_flg = 4'b1000;
        end else if (ia || ib) begin
            s1_d.spec     = 1'b1;
            s1_d.spec_res = {ia ? sa : sb, 8'hFF, 23'd0};
        end
    end

    // S2 align: sticky collects everything shifted past the round bit
    side_t       s2_q;
    logic        sub2_q;
    logic [4:0]  sh;
    logic [53:0] ext;
    logic [26:0] l2_d, s2_d, l2_q, s2s_q;

    always_comb begin
        sh   = (d1_q > 8'd27) ? 5'd27 : d1_q[4:0];
        ext  = {sig_s1_q, 30'd0} >> sh;
        l2_d = {sig_l1_q, 3'b000};
        s2_d = {ext[53:28], ext[27] | (|ext[26:0])};
    end

    // S3 add and leading-zero count
    side_t       s3_q;
    logic [27:0] sum3_d, sum3_q;
    logic [4:0]  lzc3_d, lzc3_q;

    always_comb begin
        sum3_d = sub2_q ? ({1'b0, l2_q} - {1'b0, s2s_q}) : ({1'b0, l2_q} + {1'b0, s2s_q});
        lzc3_d = 5'd28;
        for (int i = 0; i < 28; i++)
            if (sum3_d[i]) lzc3_d = 5'(27 - i);
    end

    // S4 normalize, round to nearest even, pack
    logic [26:0]       nrm;
    logic signed [9:0] exp_n, exp_r;
    logic              rnd;
    logic [24:0]       mant;
    logic [22:0]       frac;
    logic [31:0]       res4_d, result_q;
    logic [3:0]        flg4_d, flags_q;
    logic [TAG_W-1:0]  tag_out_q;

    always_comb begin
        if (sum3_q[27]) begin
            nrm   = {sum3_q[27:2], sum3_q[1] | sum3_q[0]};
            exp_n = $signed({2'b00, s3_q.exp}) + 10'sd1;
        end else begin
            nrm   = sum3_q[26:0] << (lzc3_q - 5'd1);
            exp_n = $signed({2'b00, s3_q.exp}) - $signed({5'd0, lzc3_q}) + 10'sd1;
        end
        rnd    = nrm[2] & (nrm[1] | nrm[0] | nrm[3]);
        mant   = {1'b0, nrm[26:3]} + {24'd0, rnd};
        exp_r  = exp_n + $signed({9'd0, mant[24]});
        frac   = mant[24] ? mant[23:1] : mant[22:0];
        res4_d = {s3_q.sign, exp_r[7:0], frac};
        flg4_d = {3'b000, |nrm[2:0]};
        if (s3_q.spec) begin
            res4_d = s3_q.spec_res;
            flg4_d = s3_q.spec_flg;
        end else if (sum3_q == 28'd0) begin
            res4_d = {s3_q.zsign, 31'd0};
            flg4_d = 4'b0000;
        end else if (exp_r > 10'sd254) begin
            res4_d = {s3_q.sign, 8'hFF, 23'd0};
            flg4_d = 4'b0101;
        end else if (exp_r < 10'sd1) begin
            res4_d = {s3_q.sign, 31'd0};
            flg4_d = 4'b0011;
        end
    end

    // Datapath ranks carry junk through bubbles; only the valid bits and outputs need reset.
    always_ff @(posedge clk) begin
        a0_q       <= din1;
        b0_q       <= din2;
        op0_q      <= op;
        tag_pipe_q <= {tag_pipe_q[STAGES-2:0], tag_in};
        s1_q       <= s1_d;
        sig_l1_q   <= sig_l1_d;
        sig_s1_q   <= sig_s1_d;
        d1_q       <= d1_d;
        sub1_q     <= sub1_d;
        s2_q       <= s1_q;
        sub2_q     <= sub1_q;
        l2_q       <= l2_d;
        s2s_q      <= s2_d;
        s3_q       <= s2_q;
        sum3_q     <= sum3_d;
        lzc3_q     <= lzc3_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe_q <= '0;
            result_q   <= '0;
            flags_q    <= '0;
            tag_out_q  <= '0;
        end else begin
            vld_pipe_q <= {vld_pipe_q[STAGES-1:0], dval};
            if (vld_pipe_q[STAGES-1]) begin
                result_q  <= res4_d;
                flags_q   <= flg4_d;
                tag_out_q <= tag_pipe_q[STAGES-1];
            end
        end
    end

    assign rdy     = vld_pipe_q[STAGES];
    assign result  = result_q;
    assign flags   = flags_q;
    assign tag_out = tag_out_q;
endmodule
